// File: rtl/delay_timer_arbiter.sv
// Purpose : one shared prescaler/down-counter handed round-robin to NUM_REQ delay requesters.
// Latency : grant one cycle after a winning req; done at G + D*DIV; next arbitration one cycle later.
// Backpr. : level req is the only handshake; a losing requester simply waits in IDLE arbitration.
//
// Ports:
//   clk_50MHz  system clock            reset      async, active-high
//   req        per-requester level     delay_in   per-requester delay, slice i = [i*CNT_W +: CNT_W]
//   grant      one-hot owner           done       one-cycle expiry pulse for the owner
//   tick       tick-boundary pulse     remaining  ticks left for owner (0 when not running)
//   busy       state != IDLE
module delay_timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DIV     = 50_000_000,
    parameter int CNT_W   = 8
) (
    input  logic                     clk_50MHz,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] delay_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     tick,
    output logic [CNT_W-1:0]         remaining,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                tick_q, tick_d;
    logic                busy_q, busy_d;
    // Set on abort: the cycle after an abort behaves like a DONE cycle, so
    // the next arbitration is held off by one cycle either way.
    logic                cool_q, cool_d;

    logic                arb_found;
    logic [IDX_W-1:0]    arb_sel;
    logic [CNT_W-1:0]    arb_delay;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int j;
        arb_found = 1'b0;
        arb_sel   = '0;
        j         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_q) + k) % NUM_REQ;
            if (!arb_found && req[j]) begin
                arb_found = 1'b1;
                arb_sel   = IDX_W'(j);
            end
        end
    end

    assign arb_delay = delay_in[int'(arb_sel)*CNT_W +: CNT_W];

    // State register
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!cool_q && arb_found) begin
                    state_d = (arb_delay != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!req[idx_q]) begin
                    state_d = S_IDLE;
                end else if (tick_q && (rem_q == CNT_W'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        idx_d   = idx_q;
        last_d  = last_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        cool_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cool_q && arb_found) begin
                    idx_d   = arb_sel;
                    last_d  = arb_sel;
                    rem_d   = arb_delay;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (!req[idx_q]) begin
                    presc_d = '0;
                    cool_d  = 1'b1;
                end else if (tick_q) begin
                    // tick_q marks the prescaler sitting at its terminal count.
                    presc_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                end else begin
                    presc_d = presc_q + PS_W'(1);
                end
            end
            default: begin
                presc_d = '0;
            end
        endcase

        if (state_d != S_RUN) begin
            rem_d   = '0;
            presc_d = '0;
        end
        grant_d = (state_d == S_RUN)  ? onehot(idx_d) : '0;
        done_d  = (state_d == S_DONE) ? onehot(idx_d) : '0;
        tick_d  = (state_d == S_RUN) && (presc_d == PS_LAST);
        busy_d  = (state_d != S_IDLE);
    end

    // Datapath / output registers
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            last_q  <= LAST_RST;
            presc_q <= '0;
            rem_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            cool_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            cool_q  <= cool_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign tick      = tick_q;
    assign remaining = rem_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Purpose : self-checking bench for delay_timer_arbiter (NUM_REQ=4, DIV=5, CNT_W=8).
// Latency : compares every cycle on the falling edge against a cycle-count reference model.
// Backpr. : none; inputs are driven just after the falling edge and held for a full cycle.
module tb_delay_timer_arbiter;

    localparam int NR  = 4;
    localparam int DIV = 5;
    localparam int CW  = 8;

    logic           clk_50MHz = 1'b0;
    logic           reset;
    logic [NR-1:0]  req;
    logic [NR*CW-1:0] delay_in;
    logic [NR-1:0]  grant;
    logic [NR-1:0]  done;
    logic           tick;
    logic [CW-1:0]  remaining;
    logic           busy;

    int errors = 0;
    int checks = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    delay_timer_arbiter #(.NUM_REQ(NR), .DIV(DIV), .CNT_W(CW)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .req       (req),
        .delay_in  (delay_in),
        .grant     (grant),
        .done      (done),
        .tick      (tick),
        .remaining (remaining),
        .busy      (busy)
    );

    // Reference model: who owns the timer and how many cycles since its grant.
    int m_owner;    // -1 when nobody owns the timer
    int m_elapsed;  // cycles since the grant cycle
    int m_dly;      // ticks requested by the owner
    int m_done;     // requester whose done pulse is showing, -1 if none
    int m_last;     // previous winner
    bit m_cool;     // this cycle follows an abort, no arbitration

    task automatic model_reset();
        m_owner = -1; m_elapsed = 0; m_dly = 0; m_done = -1; m_last = NR - 1; m_cool = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        int w;
        int d;
        found = 1'b0;
        w = 0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_cool  = 1'b1;
            end else if (m_elapsed + 1 == m_dly * DIV) begin
                m_done  = m_owner;
                m_owner = -1;
            end else begin
                m_elapsed++;
            end
        end else if (m_done >= 0) begin
            m_done = -1;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                if (!found && req[(m_last + k) % NR]) begin
                    found = 1'b1;
                    w = (m_last + k) % NR;
                end
            end
            if (found) begin
                m_last = w;
                d = int'(delay_in[w*CW +: CW]);
                if (d == 0) begin
                    m_done = w;
                end else begin
                    m_owner = w; m_elapsed = 0; m_dly = d;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [NR-1:0] eg, ed;
        logic          et, eb;
        logic [CW-1:0] er;
        eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
        ed = (m_done  >= 0) ? NR'(1 << m_done)  : '0;
        et = (m_owner >= 0) && ((m_elapsed % DIV) == DIV - 1);
        er = (m_owner >= 0) ? CW'(m_dly - m_elapsed / DIV) : '0;
        eb = (m_owner >= 0) || (m_done >= 0);
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_done", 32'(done), 32'(ed));
        chk("model_tick", 32'(tick), 32'(et));
        chk("model_remaining", 32'(remaining), 32'(er));
        chk("model_busy", 32'(busy), 32'(eb));
    endtask

    // One clock: DUT and model both consume the inputs present at the rising
    // edge; outputs are compared on the following falling edge.
    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50MHz);
            model_step();
            @(negedge clk_50MHz);
            compare_model();
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_tick"}, 32'(tick), 32'd0);
        chk({nm, "_remaining"}, 32'(remaining), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Reset with random req present; all outputs must read zero.
    task automatic do_reset();
        req      = NR'($urandom);
        delay_in = $urandom;
        reset    = 1'b1;
        @(negedge clk_50MHz);
        model_reset();
        chk_idle_outputs("reset");
        @(negedge clk_50MHz);
        reset = 1'b0;
        req   = '0;
    endtask

    typedef struct {
        logic [NR-1:0]    r;
        logic [NR*CW-1:0] dly;
        int               off;
        logic [NR-1:0]    g;
        logic [NR-1:0]    d;
        logic             t;
        logic [CW-1:0]    rem;
        logic             b;
    } vec_t;

    vec_t vt[8];

    initial begin
        reset    = 1'b1;
        req      = '0;
        delay_in = '0;
        model_reset();

        //          req      delays         off  grant    done     tick rem  busy
        vt[0] = '{4'b0001, 32'h0000_0002,  1, 4'b0001, 4'b0000, 1'b0, 8'd2, 1'b1};
        vt[1] = '{4'b0100, 32'h0000_0000,  1, 4'b0000, 4'b0100, 1'b0, 8'd0, 1'b1};
        vt[2] = '{4'b0110, 32'h0005_0300,  1, 4'b0010, 4'b0000, 1'b0, 8'd3, 1'b1};
        vt[3] = '{4'b1000, 32'h0100_0000,  5, 4'b1000, 4'b0000, 1'b1, 8'd1, 1'b1};
        vt[4] = '{4'b1000, 32'h0100_0000,  6, 4'b0000, 4'b1000, 1'b0, 8'd0, 1'b1};
        vt[5] = '{4'b0001, 32'h0000_0002, 10, 4'b0001, 4'b0000, 1'b1, 8'd1, 1'b1};
        vt[6] = '{4'b0001, 32'h0000_0002, 11, 4'b0000, 4'b0001, 1'b0, 8'd0, 1'b1};
        vt[7] = '{4'b1111, 32'h0101_0101,  8, 4'b0010, 4'b0000, 1'b0, 8'd1, 1'b1};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            req      = vt[v].r;
            delay_in = vt[v].dly;
            advance(vt[v].off);
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].g));
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(vt[v].d));
            chk($sformatf("vec%0d_tick", v), 32'(tick), 32'(vt[v].t));
            chk($sformatf("vec%0d_remaining", v), 32'(remaining), 32'(vt[v].rem));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].b));
        end

        // Ticks at G+4, G+9, G+14 with remaining 3,2,1; done at G+15.
        do_reset();
        req = 4'b0001; delay_in = 32'h0000_0003;
        advance(1);
        advance(4);
        chk("d3_tick1", 32'(tick), 32'd1);
        chk("d3_rem_at_tick1", 32'(remaining), 32'd3);
        advance(1);
        chk("d3_rem_after_tick1", 32'(remaining), 32'd2);
        advance(4);
        chk("d3_tick2", 32'(tick), 32'd1);
        advance(5);
        chk("d3_tick3", 32'(tick), 32'd1);
        chk("d3_rem_at_tick3", 32'(remaining), 32'd1);
        advance(1);
        chk("d3_done", 32'(done), 32'h1);
        chk("d3_grant_low", 32'(grant), 32'd0);

        // Round robin with every requester asking for one tick.
        do_reset();
        req = 4'b1111; delay_in = 32'h0101_0101;
        advance(1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr%0d_grant_first", i), 32'(grant), 32'(1 << (i % NR)));
            advance(4);
            chk($sformatf("rr%0d_grant_last", i), 32'(grant), 32'(1 << (i % NR)));
            advance(1);
            chk($sformatf("rr%0d_done", i), 32'(done), 32'(1 << (i % NR)));
            chk($sformatf("rr%0d_gap", i), 32'(grant), 32'd0);
            advance(2);
        end

        // Abort: req0 low during G+7 -> grant low at G+8, no done, grant1 at G+10.
        do_reset();
        req = 4'b0011; delay_in = 32'h0000_020A;
        advance(1);
        chk("abort_grant0", 32'(grant), 32'h1);
        advance(7);
        chk("abort_grant0_held", 32'(grant), 32'h1);
        req = 4'b0010;
        advance(1);
        chk("abort_grant_low", 32'(grant), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        advance(1);
        chk("abort_gap", 32'(grant), 32'd0);
        advance(1);
        chk("abort_grant1", 32'(grant), 32'h2);

        // Reset during RUN clears outputs at once; first tick is timed from the new grant.
        do_reset();
        req = 4'b0001; delay_in = 32'h0000_000A;
        advance(7);
        chk("rr_pre_grant", 32'(grant), 32'h1);
        reset = 1'b1;
        #1;
        model_reset();
        chk_idle_outputs("midrun_reset");
        @(negedge clk_50MHz);
        reset = 1'b0;
        advance(1);
        chk("post_reset_grant", 32'(grant), 32'h1);
        chk("post_reset_rem", 32'(remaining), 32'd10);
        advance(3);
        chk("post_reset_no_tick", 32'(tick), 32'd0);
        advance(1);
        chk("post_reset_tick", 32'(tick), 32'd1);

        // Randomised traffic against the model, with changing delays and aborts.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            req = NR'($urandom);
            for (int c = 0; c < 600; c++) begin
                for (int b = 0; b < NR; b++) begin
                    if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
                    delay_in[b*CW +: CW] = CW'($urandom_range(0, 4));
                end
                advance(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
